// File: rtl/RS5_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : RS5_pkg
// Purpose  : Shared register offsets, serializer state type and STATUS packing
// Revision : 1.0 - initial release
// ============================================================================
package RS5_pkg;

  localparam logic [3:0] c_OFF_TXDATA = 4'h0;
  localparam logic [3:0] c_OFF_STATUS = 4'h4;
  localparam logic [3:0] c_OFF_COUNT  = 4'h8;

  localparam int c_FRAME_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  function automatic logic [31:0] status_word(
    input logic full,
    input logic empty,
    input logic busy,
    input logic overflow,
    input logic irq_pending
  );
    return {27'b0, irq_pending, overflow, busy, empty, full};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Synchronous FIFO; a push to a full FIFO is accepted only when a
//            pop happens in the same cycle, and a pop on an empty FIFO is ignored
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL_COUNT = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_FULL_COUNT);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign rd_data   = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_periph.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_tx_periph
// Purpose  : Bus-mapped UART transmitter with TX FIFO (8N1, LSB first).
//            Define UART_TX_IRQ_EN to enable the TX-done interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_periph
  import RS5_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int c_DIV_W = $clog2(CLK_DIV);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [2:0] c_LAST_BIT = 3'(c_FRAME_DATA_BITS - 1);

  logic               w_wr;
  logic               w_rd;
  logic               w_wr_txdata;
  logic               w_wr_status;
  logic               w_fifo_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [7:0]         w_fifo_head;
  logic [c_CNT_W-1:0] w_fifo_count;

  uart_tx_state_e     r_state;
  uart_tx_state_e     w_state_next;
  logic [c_DIV_W-1:0] r_div;
  logic [c_DIV_W-1:0] w_div_next;
  logic [2:0]         r_bit_idx;
  logic [2:0]         w_bit_idx_next;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_next;
  logic               r_tx;
  logic               w_tx_next;
  logic               w_bit_end;
  logic               w_irq_set;

  logic               r_overflow;
  logic               w_ovf_set;
  logic               w_irq_pending;
  logic [31:0]        w_rdata;
  logic [31:0]        r_rdata;
  logic               w_unused_bits;

  assign w_wr        = enable_i && (we_i != 4'b0);
  assign w_rd        = enable_i && (we_i == 4'b0);
  assign w_wr_txdata = w_wr && (addr_i[3:0] == c_OFF_TXDATA);
  assign w_wr_status = w_wr && (addr_i[3:0] == c_OFF_STATUS);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_wr_txdata),
    .pop     (w_fifo_pop),
    .wr_data (data_i[7:0]),
    .rd_data (w_fifo_head),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_div     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_div     <= w_div_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
    end
  end

  assign w_bit_end = (r_div == c_DIV_LAST);

  always_comb begin
    w_state_next   = r_state;
    w_div_next     = r_div;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_fifo_pop     = 1'b0;
    w_irq_set      = 1'b0;
    w_tx_next      = 1'b1;

    if (r_state == IDLE) w_div_next = '0;
    else                 w_div_next = w_bit_end ? '0 : r_div + 1'b1;

    unique case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_state_next   = START;
          w_fifo_pop     = 1'b1;
          w_shift_next   = w_fifo_head;
          w_bit_idx_next = '0;
        end
      end
      START: begin
        if (w_bit_end) w_state_next = DATA;
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == c_LAST_BIT) begin
            w_state_next = STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
            w_shift_next   = {1'b0, r_shift[7:1]};
          end
        end
      end
      STOP: begin
        // Chain straight into the next frame so back-to-back bytes have no idle gap.
        if (w_bit_end) begin
          if (!w_fifo_empty) begin
            w_state_next   = START;
            w_fifo_pop     = 1'b1;
            w_shift_next   = w_fifo_head;
            w_bit_idx_next = '0;
          end else begin
            w_state_next = IDLE;
            w_irq_set    = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  assign tx_o = r_tx;

  // A push into a full FIFO is only lost when no pop frees a slot that cycle.
  assign w_ovf_set = w_wr_txdata && w_fifo_full && !w_fifo_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (w_wr_status && data_i[3]) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic r_irq_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_pending <= 1'b0;
    end else if (w_irq_set) begin
      r_irq_pending <= 1'b1;
    end else if (w_wr_status && data_i[4]) begin
      r_irq_pending <= 1'b0;
    end
  end

  assign w_irq_pending = r_irq_pending;
`else
  logic w_irq_unused;

  assign w_irq_unused  = w_irq_set;
  assign w_irq_pending = 1'b0;
`endif

  assign irq_o = w_irq_pending;

  always_comb begin
    w_rdata = '0;
    case (addr_i[3:0])
      c_OFF_STATUS: w_rdata = status_word(w_fifo_full, w_fifo_empty, (r_state != IDLE),
                                          r_overflow, w_irq_pending);
      c_OFF_COUNT:  w_rdata = 32'(w_fifo_count);
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= w_rdata;
    end
  end

  assign data_o = r_rdata;

  assign w_unused_bits = ^{addr_i[31:4], data_i[31:8]};

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx_periph
// Purpose  : Directed + randomized bench with a frame-level reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_periph;

  localparam int DEPTH = 8;
  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;
`ifdef UART_TX_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [3:0]  we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        tx_o;
  logic        irq_o;

  always #5 clk = ~clk;

  uart_tx_periph #(
    .FIFO_DEPTH (DEPTH),
    .CLK_DIV    (DIV)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .enable_i (enable_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .tx_o     (tx_o),
    .irq_o    (irq_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO as a queue, serializer as a position inside a frame.
  logic [7:0]  m_fifo[$];
  int          m_pos;
  logic [7:0]  m_byte;
  logic        m_ovf;
  logic        m_irq;
  logic [31:0] m_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_tx();
    logic [9:0] frame;
    if (m_pos < 0) return 1'b1;
    frame = {1'b1, m_byte, 1'b0};
    return frame[m_pos / DIV];
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'd0;
    s[0] = (m_fifo.size() == DEPTH);
    s[1] = (m_fifo.size() == 0);
    s[2] = (m_pos >= 0);
    s[3] = m_ovf;
    s[4] = m_irq & IRQ_ON;
    return s;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_pos   = -1;
    m_byte  = 8'h00;
    m_ovf   = 1'b0;
    m_irq   = 1'b0;
    m_rdata = 32'd0;
  endtask

  task automatic model_edge();
    int   pre_size;
    logic popped;
    logic wr;
    logic irq_set;
    pre_size = m_fifo.size();
    popped   = 1'b0;
    irq_set  = 1'b0;
    wr       = enable_i && (we_i != 4'b0);
    if (enable_i && we_i == 4'b0) begin
      if (addr_i[3:0] == 4'h4)      m_rdata = model_status();
      else if (addr_i[3:0] == 4'h8) m_rdata = 32'(pre_size);
      else                          m_rdata = 32'd0;
    end
    if (m_pos < 0 || m_pos == FRAME - 1) begin
      if (pre_size != 0) begin
        m_byte = m_fifo.pop_front();
        m_pos  = 0;
        popped = 1'b1;
      end else begin
        if (m_pos == FRAME - 1) irq_set = 1'b1;
        m_pos = -1;
      end
    end else begin
      m_pos++;
    end
    if (wr && addr_i[3:0] == 4'h0) begin
      if (pre_size < DEPTH || popped) m_fifo.push_back(data_i[7:0]);
      else                            m_ovf = 1'b1;
    end
    if (wr && addr_i[3:0] == 4'h4) begin
      if (data_i[3]) m_ovf = 1'b0;
      if (data_i[4]) m_irq = 1'b0;
    end
    if (irq_set) m_irq = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_eq("tx_o",   32'(tx_o),  32'(model_tx()));
    check_eq("irq_o",  32'(irq_o), 32'(m_irq & IRQ_ON));
    check_eq("data_o", data_o,     m_rdata);
  endtask

  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] d);
    enable_i = en;
    we_i     = we;
    addr_i   = a;
    data_i   = d;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 4'hF, a, d);
    tick();
  endtask

  task automatic bus_read(input logic [31:0] a, input string tag, input logic [31:0] exp);
    drive(1'b1, 4'h0, a, 32'h0);
    tick();
    check_eq(tag, data_o, exp);
    drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    logic [3:0]  off;
    model_reset();
    rst = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check_eq("reset_tx",    32'(tx_o),  32'd1);
    check_eq("reset_data",  data_o,     32'd0);
    check_eq("reset_irq",   32'(irq_o), 32'd0);
    idle(3);
    rst = 1'b0;

    bus_read(32'h4, "status_after_reset", 32'h2);
    bus_read(32'h8, "count_after_reset",  32'h0);

    // Single frame 0x55
    bus_write(32'h0, 32'h55);
    idle(45);
    bus_read(32'h4, "status_after_frame", {27'b0, IRQ_ON, 4'b0010});
    check_eq("irq_after_frame", 32'(irq_o), 32'(IRQ_ON));
    bus_write(32'h4, 32'h10);
    check_eq("irq_cleared", 32'(irq_o), 32'd0);
    idle(2);

    // Back-to-back frames
    bus_write(32'h0, 32'hA1);
    bus_write(32'h0, 32'hB2);
    idle(2 * FRAME + 6);
    bus_read(32'h4, "status_after_b2b", {27'b0, IRQ_ON, 4'b0010});
    bus_write(32'h4, 32'h18);
    idle(2);

    // Overflow: ten consecutive writes
    for (int i = 0; i < 10; i++) bus_write(32'h0, 32'(8'h10 + i));
    bus_read(32'h4, "status_overflow", 32'hD);
    bus_read(32'h8, "count_full",      32'h8);
    bus_write(32'h4, 32'h8);
    bus_read(32'h4, "status_ovf_clear", 32'h5);
    idle(9 * FRAME + 10);
    bus_write(32'h4, 32'h18);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 900; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        drive(1'b1, 4'($urandom_range(1, 15)), {$urandom, 4'h0} >> 0 & 32'hFFFF_FFF0,
              $urandom);
      end else if (r < 50) begin
        case ($urandom_range(0, 3))
          0:       off = 4'h4;
          1:       off = 4'h8;
          2:       off = 4'h0;
          default: off = 4'($urandom);
        endcase
        drive(1'b1, 4'h0, {28'($urandom), off}, $urandom);
      end else if (r < 57) begin
        drive(1'b1, 4'($urandom_range(1, 15)), 32'h4, $urandom);
      end else if (r < 62) begin
        off = 4'($urandom_range(5, 15));
        drive(1'b1, 4'($urandom_range(1, 15)), {28'($urandom), off}, $urandom);
      end else if (r < 67) begin
        drive(1'b0, 4'($urandom), {28'($urandom), 4'h0}, $urandom);
      end else begin
        drive(1'b0, 4'h0, 32'h0, 32'h0);
      end
      tick();
    end
    idle(DEPTH * FRAME + 20);
    bus_read(32'h8, "count_drained", 32'h0);

    // Reset in the middle of data bit 3
    bus_write(32'h0, 32'h3C);
    bus_write(32'h0, 32'h99);
    idle(4 * DIV + 1);
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("midframe_tx",   32'(tx_o),  32'd1);
    check_eq("midframe_data", data_o,     32'd0);
    check_eq("midframe_irq",  32'(irq_o), 32'd0);
    idle(2);
    rst = 1'b0;
    bus_read(32'h8, "count_after_midreset", 32'h0);
    idle(FRAME + 10);
    bus_read(32'h4, "status_after_midreset", 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
